// File: rtl/nlp_pkg.sv
// Shared types and helpers for the next-line-predictor update path.
// Request bundle, bimodal constants and per-instr classification.
package nlp_pkg;

   localparam logic [1:0] BIM_STRONG_NT    = 2'b00;
   localparam logic [1:0] BIM_WEAK_TAKEN   = 2'b10;
   localparam logic [1:0] BIM_STRONG_TAKEN = 2'b11;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] target;
      logic [1:0]  bim;
      logic        should_take;
   } nlp_upd_req_t;

   typedef enum logic [1:0] {
      CLS_SKIP,
      CLS_ALLOC,
      CLS_TRAIN
   } nlp_cls_e;

   // Decide whether a retired instr needs an NLP write at all.
   function automatic nlp_cls_e classify(
      input logic        hit,
      input logic        taken,
      input logic [1:0]  bim,
      input logic [31:0] target,
      input logic [31:0] pred_target
   );
      nlp_cls_e cls;
      cls = CLS_TRAIN;
      if (!hit) begin
         cls = taken ? CLS_ALLOC : CLS_SKIP;
      end else if (taken && bim == BIM_STRONG_TAKEN
                   && target == pred_target) begin
         cls = CLS_SKIP;
      end else if (!taken && bim == BIM_STRONG_NT) begin
         cls = CLS_SKIP;
      end
      return cls;
   endfunction

endpackage

// File: rtl/nlp_upd_fifo.sv
// Two-write / one-read FIFO of NLP update requests.
// Head pops every non-empty cycle; tail entry exposed for in-place overwrite.
module nlp_upd_fifo
   import nlp_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr0_en,
   input  nlp_upd_req_t               wr0_data,
   input  logic                       wr1_en,
   input  nlp_upd_req_t               wr1_data,
   input  logic                       ovw_en,
   input  nlp_upd_req_t               ovw_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic [$clog2(DEPTH)-1:0]   tail_idx,
   output nlp_upd_req_t               head,
   output nlp_upd_req_t               tail_ent
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   nlp_upd_req_t   mem_q [DEPTH];
   nlp_upd_req_t   mem_d [DEPTH];
   logic [PW-1:0]  head_q, head_d;
   logic [PW-1:0]  tail_q, tail_d;
   logic [CW-1:0]  count_q, count_d;
   logic           pop;

   // Next-state: optional tail overwrite, up to two pushes, one pop.
   always_comb begin
      mem_d   = mem_q;
      pop     = (count_q != '0);
      if (ovw_en) begin
         mem_d[tail_q - PW'(1)] = ovw_data;
      end
      if (wr0_en) begin
         mem_d[tail_q] = wr0_data;
      end
      if (wr1_en) begin
         mem_d[tail_q + PW'(1)] = wr1_data;
      end
      tail_d  = tail_q + PW'(wr0_en) + PW'(wr1_en);
      head_d  = head_q + PW'(pop);
      count_d = count_q + CW'(wr0_en) + CW'(wr1_en) - CW'(pop);
   end

   // State registers; storage cleared so outputs read zero after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign count    = count_q;
   assign tail_idx = tail_q - PW'(1);
   assign head     = mem_q[head_q];
   assign tail_ent = mem_q[tail_q - PW'(1)];

endmodule

// File: rtl/nlp_update_gen.sv
// Commit-side NLP training update generator: classify, queue, drain 1/cycle.
// Optional NLP_UPD_COALESCE_EN merges same-PC requests instead of queueing.
module nlp_update_gen
   import nlp_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DROP_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        cmt_valid,
   input  logic [1:0][31:0]  cmt_pc,
   input  logic [1:0]        cmt_taken,
   input  logic [1:0][31:0]  cmt_target,
   input  logic [1:0]        cmt_pred_hit,
   input  logic [1:0][1:0]   cmt_pred_bim,
   input  logic [1:0][31:0]  cmt_pred_target,
   output logic              upd_valid,
   output logic [31:0]       upd_pc,
   output logic [31:0]       upd_target,
   output logic [1:0]        upd_bim,
   output logic              upd_should_take,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam int CW = $clog2(DEPTH) + 1;

   nlp_upd_req_t      cand [2];
   logic [1:0]        cand_v;
   nlp_upd_req_t      l0, l1, ovw_data, head, tail_ent;
   logic              l0_v, l1_v, ovw_en;
   logic              wr0_en, wr1_en, drop;
   logic [CW-1:0]     count, cap;
   logic [CW-2:0]     tail_idx;
   logic [DROP_W-1:0] drop_q, drop_d;

   // Per-slot classification into a candidate request.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         nlp_cls_e cls;
         cls = classify(cmt_pred_hit[i], cmt_taken[i],
                        cmt_pred_bim[i], cmt_target[i],
                        cmt_pred_target[i]);
         cand_v[i] = cmt_valid[i] && (cls != CLS_SKIP);
         cand[i]   = '{pc:          cmt_pc[i],
                       target:      cmt_target[i],
                       bim:         BIM_WEAK_TAKEN,
                       should_take: 1'b1};
         if (cls == CLS_TRAIN) begin
            cand[i].target      = cmt_taken[i] ? cmt_target[i]
                                               : cmt_pred_target[i];
            cand[i].bim         = cmt_pred_bim[i];
            cand[i].should_take = cmt_taken[i];
         end
      end
   end

   // Compact candidates, optionally coalesce, then fit into free space.
   always_comb begin
      logic [1:0] cv;
      cv       = cand_v;
      ovw_en   = 1'b0;
      ovw_data = cand[0];
`ifdef NLP_UPD_COALESCE_EN
      if (cv[0] && cv[1] && cand[0].pc == cand[1].pc) begin
         cv[0] = 1'b0;
      end
`endif
      l0_v = |cv;
      l0   = cv[0] ? cand[0] : cand[1];
      l1_v = &cv;
      l1   = cand[1];
`ifdef NLP_UPD_COALESCE_EN
      // Tail entry is safe to rewrite only if it is not the head leaving now.
      if (l0_v && count > CW'(1) && l0.pc == tail_ent.pc) begin
         ovw_en   = 1'b1;
         ovw_data = l0;
         l0_v     = l1_v;
         l0       = l1;
         l1_v     = 1'b0;
      end
`endif
      cap    = CW'(DEPTH) - count + CW'(count != '0);
      wr0_en = l0_v;
      wr1_en = l1_v && (cap >= CW'(2));
      drop   = l1_v && (cap < CW'(2));
   end

`ifndef NLP_UPD_COALESCE_EN
   logic unused_tail;
   assign unused_tail = ^{tail_ent, tail_idx};
`else
   logic unused_tail;
   assign unused_tail = ^tail_idx;
`endif

   nlp_upd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr0_en   (wr0_en),
      .wr0_data (l0),
      .wr1_en   (wr1_en),
      .wr1_data (l1),
      .ovw_en   (ovw_en),
      .ovw_data (ovw_data),
      .count    (count),
      .tail_idx (tail_idx),
      .head     (head),
      .tail_ent (tail_ent)
   );

   // Saturating count of requests lost to a full queue.
   always_comb begin
      drop_d = drop_q;
      if (drop && drop_q != '1) begin
         drop_d = drop_q + DROP_W'(1);
      end
   end

   // Drop counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_q <= '0;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign drop_cnt        = drop_q;
   assign upd_valid       = (count != '0);
   assign upd_pc          = head.pc;
   assign upd_target      = head.target;
   assign upd_bim         = head.bim;
   assign upd_should_take = head.should_take;

endmodule

// File: tb/tb_nlp_update_gen.sv
// Directed + random bench for nlp_update_gen against a queue-based model.
// Define NLP_UPD_COALESCE_EN for both bench and RTL to cover coalescing.
module tb_nlp_update_gen;

   localparam int DEPTH  = 8;
   localparam int DROP_W = 4;
   localparam int DMAX   = (1 << DROP_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [1:0]        cmt_valid;
   logic [1:0][31:0]  cmt_pc;
   logic [1:0]        cmt_taken;
   logic [1:0][31:0]  cmt_target;
   logic [1:0]        cmt_pred_hit;
   logic [1:0][1:0]   cmt_pred_bim;
   logic [1:0][31:0]  cmt_pred_target;
   logic              upd_valid;
   logic [31:0]       upd_pc;
   logic [31:0]       upd_target;
   logic [1:0]        upd_bim;
   logic              upd_should_take;
   logic [DROP_W-1:0] drop_cnt;

   nlp_update_gen #(
      .DEPTH  (DEPTH),
      .DROP_W (DROP_W)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .cmt_valid       (cmt_valid),
      .cmt_pc          (cmt_pc),
      .cmt_taken       (cmt_taken),
      .cmt_target      (cmt_target),
      .cmt_pred_hit    (cmt_pred_hit),
      .cmt_pred_bim    (cmt_pred_bim),
      .cmt_pred_target (cmt_pred_target),
      .upd_valid       (upd_valid),
      .upd_pc          (upd_pc),
      .upd_target      (upd_target),
      .upd_bim         (upd_bim),
      .upd_should_take (upd_should_take),
      .drop_cnt        (drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] target;
      logic [1:0]  bim;
      logic        take;
   } mreq_t;

   mreq_t q[$];
   int    drops;
   int    n_cmp;
   int    n_err;

   task automatic set_slot(input int s, input bit hit, input bit taken,
                           input logic [31:0] pc, input logic [31:0] tgt,
                           input logic [1:0] bim,
                           input logic [31:0] ptgt);
      cmt_valid[s]       = 1'b1;
      cmt_pred_hit[s]    = hit;
      cmt_taken[s]       = taken;
      cmt_pc[s]          = pc;
      cmt_target[s]      = tgt;
      cmt_pred_bim[s]    = bim;
      cmt_pred_target[s] = ptgt;
   endtask

   function automatic bit ref_req(input int s, output mreq_t r);
      r = '{cmt_pc[s], cmt_target[s], 2'b10, 1'b1};
      if (!cmt_pred_hit[s]) return cmt_taken[s];
      if (cmt_taken[s] && cmt_pred_bim[s] == 2'b11
          && cmt_target[s] == cmt_pred_target[s]) return 1'b0;
      if (!cmt_taken[s] && cmt_pred_bim[s] == 2'b00) return 1'b0;
      r.target = cmt_taken[s] ? cmt_target[s] : cmt_pred_target[s];
      r.bim    = cmt_pred_bim[s];
      r.take   = cmt_taken[s];
      return 1'b1;
   endfunction

   task automatic model_edge();
      mreq_t c[$];
      mreq_t r;
      int    cap;
      for (int s = 0; s < 2; s++) begin
         if (cmt_valid[s] && ref_req(s, r)) c.push_back(r);
      end
`ifdef NLP_UPD_COALESCE_EN
      if (c.size() == 2 && c[0].pc == c[1].pc) c.delete(0);
      if (c.size() > 0 && q.size() > 1 && q[q.size()-1].pc == c[0].pc) begin
         q[q.size()-1] = c[0];
         c.delete(0);
      end
`endif
      cap = DEPTH - q.size() + ((q.size() != 0) ? 1 : 0);
      if (q.size() > 0) void'(q.pop_front());
      foreach (c[k]) begin
         if (k < cap) q.push_back(c[k]);
         else drops++;
      end
   endtask

   task automatic check(input string tag);
      bit ev;
      int dexp;
      ev   = (q.size() != 0);
      dexp = (drops > DMAX) ? DMAX : drops;
      n_cmp++;
      assert (upd_valid === ev) else begin
         n_err++;
         $error("FAIL %s upd_valid got %0b exp %0b", tag, upd_valid, ev);
      end
      if (ev) begin
         n_cmp++;
         assert ({upd_pc, upd_target, upd_bim, upd_should_take} ===
                 {q[0].pc, q[0].target, q[0].bim, q[0].take}) else begin
            n_err++;
            $error("FAIL %s upd got %h/%h/%b/%b exp %h/%h/%b/%b", tag,
                   upd_pc, upd_target, upd_bim, upd_should_take,
                   q[0].pc, q[0].target, q[0].bim, q[0].take);
         end
      end
      n_cmp++;
      assert (drop_cnt === DROP_W'(dexp)) else begin
         n_err++;
         $error("FAIL %s drop_cnt got %0d exp %0d", tag, drop_cnt, dexp);
      end
   endtask

   task automatic cycle(input string tag);
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check(tag);
      cmt_valid = 2'b00;
   endtask

   task automatic reset_now(input string tag);
      rst_n = 1'b0;
      #1;
      q.delete();
      drops = 0;
      check(tag);
      n_cmp++;
      assert ({upd_pc, upd_target, upd_bim, upd_should_take} === 67'd0)
      else begin
         n_err++;
         $error("FAIL %s upd fields got %h/%h/%b/%b exp 0", tag,
                upd_pc, upd_target, upd_bim, upd_should_take);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      drops = 0;
      cmt_valid       = '0;
      cmt_pc          = '0;
      cmt_taken       = '0;
      cmt_target      = '0;
      cmt_pred_hit    = '0;
      cmt_pred_bim    = '0;
      cmt_pred_target = '0;
      @(negedge clk);
      reset_now("por");

      // Single allocate, then queue empties.
      set_slot(0, 0, 1, 32'h1000, 32'h2000, 2'b01, 32'h0);
      cycle("alloc");
      n_cmp++;
      assert ({upd_valid, upd_pc, upd_target, upd_bim, upd_should_take}
              === {1'b1, 32'h1000, 32'h2000, 2'b10, 1'b1}) else begin
         n_err++;
         $error("FAIL alloc_const got %h/%h exp 1000/2000", upd_pc, upd_target);
      end
      cycle("alloc_drain");

      // Strong-taken correct hit skipped; weak-NT hit not-taken trains.
      set_slot(0, 1, 1, 32'h1100, 32'h1200, 2'b11, 32'h1200);
      cycle("skip_st");
      set_slot(0, 1, 0, 32'h1104, 32'h1300, 2'b01, 32'h1400);
      cycle("train_nt");
      n_cmp++;
      assert ({upd_valid, upd_target, upd_bim, upd_should_take}
              === {1'b1, 32'h1400, 2'b01, 1'b0}) else begin
         n_err++;
         $error("FAIL train_const got %h/%b/%b exp 1400/01/0",
                upd_target, upd_bim, upd_should_take);
      end
      set_slot(0, 1, 0, 32'h1108, 32'h1300, 2'b00, 32'h1400);
      set_slot(1, 0, 0, 32'h110c, 32'h1300, 2'b10, 32'h1400);
      cycle("skip_nt");
      cycle("idle0");

      // Dual allocates until the queue overflows, then drain in order.
      for (int i = 0; i < 8; i++) begin
         set_slot(0, 0, 1, 32'h5000 + 32'(i * 8), 32'h6000 + 32'(i), 2'b00, 0);
         set_slot(1, 0, 1, 32'h5004 + 32'(i * 8), 32'h7000 + 32'(i), 2'b00, 0);
         cycle("dual_fill");
      end
      n_cmp++;
      assert (drop_cnt === 4'd1) else begin
         n_err++;
         $error("FAIL dual_drop got %0d exp 1", drop_cnt);
      end
      for (int i = 0; i < 10; i++) cycle("dual_drain");

      // Same-PC pair in one cycle.
      set_slot(0, 0, 1, 32'h3000, 32'h3a00, 2'b00, 0);
      set_slot(1, 1, 1, 32'h3000, 32'h3b00, 2'b01, 32'h3c00);
      cycle("same_pc");
      for (int i = 0; i < 3; i++) cycle("same_pc_drain");

      // Async reset in the middle of a drain.
      for (int i = 0; i < 4; i++) begin
         set_slot(0, 0, 1, 32'h8000 + 32'(i * 8), 32'h9000, 2'b00, 0);
         set_slot(1, 0, 1, 32'h8004 + 32'(i * 8), 32'h9100, 2'b00, 0);
         cycle("pre_rst");
      end
      reset_now("mid_rst");
      for (int i = 0; i < 3; i++) cycle("post_rst");

      // Drop counter saturation.
      for (int i = 0; i < 30; i++) begin
         set_slot(0, 0, 1, 32'hA000 + 32'(i * 8), 32'hB000, 2'b00, 0);
         set_slot(1, 0, 1, 32'hA004 + 32'(i * 8), 32'hB100, 2'b00, 0);
         cycle("sat");
      end
      n_cmp++;
      assert (drop_cnt === 4'hF) else begin
         n_err++;
         $error("FAIL sat_const got %0d exp 15", drop_cnt);
      end
      for (int i = 0; i < 10; i++) cycle("sat_drain");
      reset_now("rst2");

      // Random traffic over a small PC pool.
      for (int n = 0; n < 400; n++) begin
         for (int s = 0; s < 2; s++) begin
            logic [31:0] tgt;
            tgt = {$urandom_range(0, 255), 2'b00};
            cmt_valid[s]       = 1'($urandom);
            cmt_pred_hit[s]    = 1'($urandom);
            cmt_taken[s]       = 1'($urandom);
            cmt_pc[s]          = 32'h4000 + {$urandom_range(0, 3), 2'b00};
            cmt_target[s]      = tgt;
            cmt_pred_bim[s]    = 2'($urandom);
            cmt_pred_target[s] = ($urandom_range(0, 1) == 1) ? tgt
                                 : {$urandom_range(0, 255), 2'b00};
         end
         cycle("rand");
      end
      for (int i = 0; i < 10; i++) cycle("rand_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
